// File: rtl/permutation_iter.sv
// ----------------------------------------------------------------------------
// permutation_iter
//   Iterative 320-bit permutation (Ascon-style p12 / p8), one round per clock.
//   Each RUN cycle applies Pc (round constant) -> Ps (5-bit S-box across 64
//   columns) -> Pl (per-word linear diffusion) to the internal state register.
//
// Ports
//   clock_i       system clock, rising edge
//   reset_i       synchronous active-high reset
//   start_i       start request, honoured only while not busy
//   rounds_sel_i  0 = 12 rounds (p12), 1 = 8 rounds (p8); sampled with start_i
//   state_i       5x64 input state, word 0 = x0; sampled with start_i
//   state_o       state register; holds the result until the next load
//   round_o       round index applied on the current RUN cycle
//   busy_o        high while rounds are executing
//   done_o        one-cycle pulse, state_o valid
// ----------------------------------------------------------------------------
module permutation_iter (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             rounds_sel_i,
    input  logic [4:0][63:0] state_i,
    output logic [4:0][63:0] state_o,
    output logic [3:0]       round_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    localparam logic [3:0] LAST_ROUND = 4'd11;
    localparam logic [3:0] P8_FIRST   = 4'd4;

    fsm_t             fsm_q;
    logic [4:0][63:0] state_q;
    logic [3:0]       round_q;
    logic             busy_q;
    logic             done_q;

    logic [4:0][63:0] pc_s;
    logic [4:0][63:0] ps_s;
    logic [4:0][63:0] pl_s;

    // Round constant: upper nibble counts down from F while lower counts up,
    // giving F0, E1, ... 4B for indices 0..11.
    function automatic logic [7:0] round_const(input logic [3:0] r);
        logic [3:0] hi;
        hi = 4'hF - r;
        return {hi, r};
    endfunction

    function automatic logic [63:0] ror(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Bit-sliced form of the 5-bit S-box, all 64 columns at once.
    function automatic logic [4:0][63:0] sbox_layer(input logic [4:0][63:0] s);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        logic [4:0][63:0] r;
        x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        r[0] = x0; r[1] = x1; r[2] = x2; r[3] = x3; r[4] = x4;
        return r;
    endfunction

    function automatic logic [4:0][63:0] linear_layer(input logic [4:0][63:0] s);
        logic [4:0][63:0] r;
        r[0] = s[0] ^ ror(s[0], 19) ^ ror(s[0], 28);
        r[1] = s[1] ^ ror(s[1], 61) ^ ror(s[1], 39);
        r[2] = s[2] ^ ror(s[2],  1) ^ ror(s[2],  6);
        r[3] = s[3] ^ ror(s[3], 10) ^ ror(s[3], 17);
        r[4] = s[4] ^ ror(s[4],  7) ^ ror(s[4], 41);
        return r;
    endfunction

    always_comb begin
        pc_s        = state_q;
        pc_s[2]     = state_q[2] ^ {56'd0, round_const(round_q)};
        ps_s        = sbox_layer(pc_s);
        pl_s        = linear_layer(ps_s);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            round_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE, DONE: begin
                    // DONE reloads directly on start so back-to-back runs
                    // need no idle cycle.
                    if (start_i) begin
                        fsm_q   <= RUN;
                        state_q <= state_i;
                        round_q <= rounds_sel_i ? P8_FIRST : '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end else begin
                        fsm_q   <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                RUN: begin
                    state_q <= pl_s;
                    if (round_q == LAST_ROUND) begin
                        fsm_q  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        round_q <= round_q + 4'd1;
                    end
                end
                default: begin
                    fsm_q  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign state_o = state_q;
    assign round_o = round_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_permutation_iter.sv
module tb_permutation_iter;

    typedef logic [4:0][63:0] state_t;

    logic       clock_i = 1'b0;
    logic       reset_i;
    logic       start_i;
    logic       rounds_sel_i;
    state_t     state_i;
    state_t     state_o;
    logic [3:0] round_o;
    logic       busy_o;
    logic       done_o;

    int tests = 0;
    int fails = 0;

    permutation_iter dut (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .start_i      (start_i),
        .rounds_sel_i (rounds_sel_i),
        .state_i      (state_i),
        .state_o      (state_o),
        .round_o      (round_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clock_i = ~clock_i;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // 5-bit S-box as a lookup table; index bit 4 is x0, bit 0 is x4.
    localparam logic [4:0] SBOX [0:31] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic state_t model_round(input state_t s, input int r);
        state_t t;
        int rot_a [5] = '{19, 61, 1, 10, 7};
        int rot_b [5] = '{28, 39, 6, 17, 41};
        logic [4:0] col;
        logic [4:0] sub;
        s[2] = s[2] ^ 64'((15 - r) * 16 + r);
        for (int c = 0; c < 64; c++) begin
            for (int k = 0; k < 5; k++) col[4-k] = s[k][c];
            sub = SBOX[col];
            for (int k = 0; k < 5; k++) t[k][c] = sub[4-k];
        end
        for (int k = 0; k < 5; k++)
            s[k] = t[k] ^ rotr(t[k], rot_a[k]) ^ rotr(t[k], rot_b[k]);
        return s;
    endfunction

    function automatic state_t model_perm(input state_t s, input logic p8);
        int first = p8 ? 4 : 0;
        for (int r = first; r < 12; r++) s = model_round(s, r);
        return s;
    endfunction

    function automatic state_t rand_state();
        state_t s;
        for (int k = 0; k < 5; k++) s[k] = {$urandom, $urandom};
        return s;
    endfunction

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    // Called 1 time unit after an edge. Returns in the DONE cycle with
    // start_i low. Inputs are scrambled during RUN to show they are ignored.
    task automatic run_perm(input string tag, input state_t st, input logic p8,
                            input logic check_rounds);
        state_t exp;
        int     first;
        exp   = model_perm(st, p8);
        first = p8 ? 4 : 0;
        start_i      = 1'b1;
        state_i      = st;
        rounds_sel_i = p8;
        tick();
        for (int r = first; r < 12; r++) begin
            start_i      = 1'($urandom_range(0, 1));
            state_i      = rand_state();
            rounds_sel_i = 1'($urandom_range(0, 1));
            if (check_rounds || r == first)
                chk({tag, "_run"}, {busy_o, done_o, round_o}, {1'b1, 1'b0, 4'(r)});
            tick();
        end
        start_i = 1'b0;
        chk({tag, "_done"}, {busy_o, done_o, round_o}, {1'b0, 1'b1, 4'd11});
        chk({tag, "_state"}, state_o, exp);
    endtask

    initial begin
        state_t z;
        state_t v;
        state_t s1;
        state_t s2;
        state_t held;
        reset_i      = 1'b1;
        start_i      = 1'b1;
        rounds_sel_i = 1'b0;
        state_i      = rand_state();
        tick();
        tick();
        chk("reset_ctrl", {busy_o, done_o, round_o}, {1'b0, 1'b0, 4'd0});
        chk("reset_state", state_o, '0);
        reset_i = 1'b0;
        start_i = 1'b0;
        tick();
        chk("idle_after_reset", {busy_o, done_o, state_o}, '0);

        // All-zero input, p12.
        z = '0;
        run_perm("p12_zero", z, 1'b0, 1'b1);
        tick();

        // Fixed vector, p8.
        v[0] = 64'h0123456789ABCDEF;
        v[1] = 64'hFEDCBA9876543210;
        v[2] = 64'h0;
        v[3] = 64'hFFFFFFFFFFFFFFFF;
        v[4] = 64'hA5A5A5A5A5A5A5A5;
        run_perm("p8_vec", v, 1'b1, 1'b1);

        // Idle hold: result must stay put for 20 cycles.
        held = state_o;
        tick();
        for (int i = 0; i < 20; i++) begin
            chk("idle_hold", {busy_o, done_o, state_o}, {2'b00, held});
            tick();
        end

        // start_i held high throughout; state_i changed mid-run.
        s1 = rand_state();
        s2 = rand_state();
        start_i      = 1'b1;
        rounds_sel_i = 1'b0;
        state_i      = s1;
        tick();
        state_i = s2;
        for (int r = 0; r < 12; r++) begin
            chk("hold_run1", {busy_o, done_o, round_o}, {1'b1, 1'b0, 4'(r)});
            tick();
        end
        chk("hold_done1", {busy_o, done_o}, 2'b01);
        chk("hold_state1", state_o, model_perm(s1, 1'b0));
        tick();
        start_i = 1'b0;
        for (int r = 0; r < 12; r++) begin
            chk("hold_run2", {busy_o, done_o, round_o}, {1'b1, 1'b0, 4'(r)});
            tick();
        end
        chk("hold_done2", {busy_o, done_o}, 2'b01);
        chk("hold_state2", state_o, model_perm(s2, 1'b0));
        tick();

        // Reset during round 5 of p12.
        start_i      = 1'b1;
        rounds_sel_i = 1'b0;
        state_i      = rand_state();
        tick();
        start_i = 1'b0;
        for (int r = 0; r < 5; r++) tick();
        chk("abort_round5", {busy_o, round_o}, {1'b1, 4'd5});
        reset_i = 1'b1;
        start_i = 1'b1;
        tick();
        reset_i = 1'b0;
        start_i = 1'b0;
        chk("abort_reset", {busy_o, done_o, round_o, state_o}, '0);
        for (int i = 0; i < 15; i++) begin
            chk("abort_no_done", {busy_o, done_o}, 2'b00);
            tick();
        end
        run_perm("after_abort", rand_state(), 1'b0, 1'b1);

        // Random mix of p12/p8 with random gaps (gap 0 = back-to-back).
        for (int n = 0; n < 1000; n++) begin
            int gap;
            run_perm("rand", rand_state(), 1'($urandom_range(0, 1)), 1'b1);
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                tick();
                chk("rand_gap", {busy_o, done_o}, 2'b00);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
